// File: rtl/rr_pkg.sv
// Shared constants and ROB entry layout for the rename-side ROB/RHT ID allocator.
package rr_pkg;

    localparam int C_NUM     = 4;
    localparam int K         = 32;
    localparam int ROB_DEPTH = (C_NUM - 1) * K;
    localparam int RHT_DEPTH = C_NUM * K;
    localparam int ROBW      = $clog2(ROB_DEPTH);
    localparam int RHTW      = $clog2(RHT_DEPTH);
    localparam int ROB_CNTW  = $clog2(ROB_DEPTH + 1);
    localparam int RHT_CNTW  = $clog2(RHT_DEPTH + 1);

    localparam int DEF_INSTR_COUNT = 2;
    localparam int DEF_REC_CYCLES  = 4;

    typedef struct packed {
        logic            valid;
        logic            done;
        logic            last;
        logic [RHTW-1:0] rht_id;
    } rob_entry_s;

    // (a - b) mod ROB_DEPTH: age of a relative to b
    function automatic logic [ROBW-1:0] rob_dist(
        input logic [ROBW-1:0] a,
        input logic [ROBW-1:0] b
    );
        logic [ROBW:0] t;
        if (a >= b) t = {1'b0, a} - {1'b0, b};
        else        t = {1'b0, a} + (ROBW+1)'(ROB_DEPTH) - {1'b0, b};
        return t[ROBW-1:0];
    endfunction

    function automatic logic [RHTW-1:0] rht_dist(
        input logic [RHTW-1:0] a,
        input logic [RHTW-1:0] b
    );
        logic [RHTW:0] t;
        if (a >= b) t = {1'b0, a} - {1'b0, b};
        else        t = {1'b0, a} + (RHTW+1)'(RHT_DEPTH) - {1'b0, b};
        return t[RHTW-1:0];
    endfunction

endpackage

// File: rtl/rr_wrap_add.sv
// Modular pointer increment: (ptr + inc) mod DEPTH, DEPTH need not be a power of two.
module rr_wrap_add #(
    parameter int DEPTH = 96,
    parameter int W     = $clog2(DEPTH)
) (
    input  logic [W-1:0] ptr,
    input  logic [W-1:0] inc,
    output logic [W-1:0] sum
);

    localparam logic [W:0] LIM = (W+1)'(DEPTH);

    logic [W:0] raw;
    logic [W:0] red;

    // Operands are always < DEPTH, so one conditional subtract suffices
    always_comb begin
        raw = {1'b0, ptr} + {1'b0, inc};
        red = raw - LIM;
        sum = (raw >= LIM) ? red[W-1:0] : raw[W-1:0];
    end

endmodule

// File: rtl/rr_rob_id_allocator.sv
// ROB/RHT ID allocator: in-order allocate, writeback, thermometer commit,
// and flush rollback with a recovery window towards the rename stage.
module rr_rob_id_allocator
    import rr_pkg::*;
#(
    parameter int INSTR_COUNT = DEF_INSTR_COUNT,
    parameter int REC_CYCLES  = DEF_REC_CYCLES
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        alloc_req,
    output logic                        alloc_ready,
    output logic [INSTR_COUNT*ROBW-1:0] rec_rob_id,
    output logic [RHTW-1:0]             rec_rht_id,
    input  logic [INSTR_COUNT-1:0]      wb_en,
    input  logic [INSTR_COUNT*ROBW-1:0] wb_rob_id,
    input  logic                        flush_en,
    input  logic [ROBW-1:0]             flush_rob_id,
    output logic                        rec_en,
    output logic                        rec_busy,
    output logic [INSTR_COUNT-1:0]      valid_commit,
    output logic [INSTR_COUNT*ROBW-1:0] commit_rob_id
);

    localparam int CW = $clog2(REC_CYCLES + 1);

    rob_entry_s entries_q [ROB_DEPTH];
    rob_entry_s entries_d [ROB_DEPTH];

    logic [ROBW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [ROB_CNTW-1:0] rob_count_q, rob_count_d;
    logic [RHTW-1:0]     rht_head_q, rht_head_d, rht_tail_q, rht_tail_d;
    logic [RHT_CNTW-1:0] rht_count_q, rht_count_d;
    logic [CW-1:0]       rec_cnt_q, rec_cnt_d;
    logic                rec_en_q, rec_en_d;

    logic [ROBW-1:0] slot_id [INSTR_COUNT];
    logic [ROBW-1:0] cm_id   [INSTR_COUNT];
    logic [ROBW-1:0] wb_id   [INSTR_COUNT];

    logic [INSTR_COUNT-1:0] wb_hit;
    logic [INSTR_COUNT-1:0] commit;
    logic [ROBW-1:0]        pop;
    logic [RHTW-1:0]        nfree;
    logic                   flush_ok;
    logic [ROBW-1:0]        fid_age;
    logic                   accept;

    logic [ROBW-1:0] tail_nxt, head_nxt, fid_nxt;
    logic [RHTW-1:0] rht_tail_nxt, rht_head_nxt, rht_fid_nxt;

    for (genvar i = 0; i < INSTR_COUNT; i++) begin : g_slot
        rr_wrap_add #(.DEPTH(ROB_DEPTH)) u_slot (
            .ptr (tail_q),
            .inc (ROBW'(i)),
            .sum (slot_id[i])
        );
        rr_wrap_add #(.DEPTH(ROB_DEPTH)) u_cm (
            .ptr (head_q),
            .inc (ROBW'(i)),
            .sum (cm_id[i])
        );
        assign rec_rob_id[i*ROBW +: ROBW]    = slot_id[i];
        assign commit_rob_id[i*ROBW +: ROBW] = cm_id[i];
        assign wb_id[i]  = wb_rob_id[i*ROBW +: ROBW];
        assign wb_hit[i] = (wb_id[i] < ROBW'(ROB_DEPTH))
                         && entries_q[wb_id[i]].valid;
    end

    rr_wrap_add #(.DEPTH(ROB_DEPTH)) u_tail (
        .ptr (tail_q),
        .inc (ROBW'(INSTR_COUNT)),
        .sum (tail_nxt)
    );
    rr_wrap_add #(.DEPTH(ROB_DEPTH)) u_head (
        .ptr (head_q),
        .inc (pop),
        .sum (head_nxt)
    );
    rr_wrap_add #(.DEPTH(ROB_DEPTH)) u_fid (
        .ptr (flush_rob_id),
        .inc (ROBW'(1)),
        .sum (fid_nxt)
    );
    rr_wrap_add #(.DEPTH(RHT_DEPTH)) u_rht_tail (
        .ptr (rht_tail_q),
        .inc (RHTW'(1)),
        .sum (rht_tail_nxt)
    );
    rr_wrap_add #(.DEPTH(RHT_DEPTH)) u_rht_head (
        .ptr (rht_head_q),
        .inc (nfree),
        .sum (rht_head_nxt)
    );
    rr_wrap_add #(.DEPTH(RHT_DEPTH)) u_rht_fid (
        .ptr (entries_q[flush_rob_id].rht_id),
        .inc (RHTW'(1)),
        .sum (rht_fid_nxt)
    );

    assign rec_rht_id   = rht_tail_q;
    assign rec_en       = rec_en_q;
    assign rec_busy     = (rec_cnt_q != '0);
    assign valid_commit = commit;

    assign alloc_ready = (ROB_CNTW'(ROB_DEPTH) - rob_count_q
                          >= ROB_CNTW'(INSTR_COUNT))
                       && (rht_count_q < RHT_CNTW'(RHT_DEPTH))
                       && !rec_busy && !flush_en;
    assign accept = alloc_req && alloc_ready;

    assign flush_ok = flush_en && (flush_rob_id < ROBW'(ROB_DEPTH))
                    && entries_q[flush_rob_id].valid;
    assign fid_age  = rob_dist(flush_rob_id, head_q);

    // A flush target retiring this edge ends its packet, so it frees its RHT ID
    always_comb begin
        logic run;
        run   = 1'b1;
        pop   = '0;
        nfree = '0;
        for (int i = 0; i < INSTR_COUNT; i++) begin
            run = run && entries_q[cm_id[i]].valid
                      && entries_q[cm_id[i]].done;
            commit[i] = run;
            if (run) begin
                pop = pop + ROBW'(1);
                if (entries_q[cm_id[i]].last
                    || (flush_ok && cm_id[i] == flush_rob_id)) begin
                    nfree = nfree + RHTW'(1);
                end
            end
        end
    end

    always_comb begin
        entries_d   = entries_q;
        head_d      = head_nxt;
        tail_d      = tail_q;
        rht_head_d  = rht_head_nxt;
        rht_tail_d  = rht_tail_q;
        rob_count_d = rob_count_q - ROB_CNTW'(pop);
        rht_count_d = rht_count_q - RHT_CNTW'(nfree);
        rec_en_d    = flush_ok;
        rec_cnt_d   = rec_busy ? rec_cnt_q - CW'(1) : rec_cnt_q;

        for (int p = 0; p < INSTR_COUNT; p++) begin
            if (wb_en[p] && wb_hit[p]) entries_d[wb_id[p]].done = 1'b1;
        end
        for (int i = 0; i < INSTR_COUNT; i++) begin
            if (commit[i]) entries_d[cm_id[i]].valid = 1'b0;
        end

        if (flush_ok) begin
            for (int j = 0; j < ROB_DEPTH; j++) begin
                if (rob_dist(ROBW'(j), head_q) > fid_age) begin
                    entries_d[j].valid = 1'b0;
                end
            end
            entries_d[flush_rob_id].last = 1'b1;
            tail_d      = fid_nxt;
            rht_tail_d  = rht_fid_nxt;
            // Recomputed from pointers so a full ROB flushed at its youngest stays full
            rob_count_d = (fid_age < pop) ? '0
                        : ROB_CNTW'(fid_age - pop) + ROB_CNTW'(1);
            rht_count_d = rht_count_q - RHT_CNTW'(nfree)
                        - RHT_CNTW'(rht_dist(rht_tail_q, rht_fid_nxt));
            rec_cnt_d   = CW'(REC_CYCLES);
        end else if (accept) begin
            for (int i = 0; i < INSTR_COUNT; i++) begin
                entries_d[slot_id[i]].valid  = 1'b1;
                entries_d[slot_id[i]].done   = 1'b0;
                entries_d[slot_id[i]].last   = (i == INSTR_COUNT - 1);
                entries_d[slot_id[i]].rht_id = rht_tail_q;
            end
            tail_d      = tail_nxt;
            rht_tail_d  = rht_tail_nxt;
            rob_count_d = rob_count_q + ROB_CNTW'(INSTR_COUNT)
                        - ROB_CNTW'(pop);
            rht_count_d = rht_count_q + RHT_CNTW'(1) - RHT_CNTW'(nfree);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < ROB_DEPTH; j++) entries_q[j] <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            rob_count_q <= '0;
            rht_head_q  <= '0;
            rht_tail_q  <= '0;
            rht_count_q <= '0;
            rec_cnt_q   <= '0;
            rec_en_q    <= 1'b0;
        end else begin
            for (int j = 0; j < ROB_DEPTH; j++) entries_q[j] <= entries_d[j];
            head_q      <= head_d;
            tail_q      <= tail_d;
            rob_count_q <= rob_count_d;
            rht_head_q  <= rht_head_d;
            rht_tail_q  <= rht_tail_d;
            rht_count_q <= rht_count_d;
            rec_cnt_q   <= rec_cnt_d;
            rec_en_q    <= rec_en_d;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            for (int p = 0; p < INSTR_COUNT; p++) begin
                if (wb_en[p]) assert (wb_hit[p])
                    else $error("writeback to invalid rob id %0d", wb_id[p]);
            end
            if (flush_en) assert (flush_ok)
                else $error("flush to invalid rob id %0d", flush_rob_id);
        end
    end

endmodule

// File: tb/tb_rr_rob_id_allocator.sv
// Directed bench: allocation, in-order commit, full/wrap, flush recovery
// and asynchronous reset of rr_rob_id_allocator.
module tb_rr_rob_id_allocator;
    import rr_pkg::*;

    localparam int IC = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              alloc_req = 1'b0;
    logic              alloc_ready;
    logic [IC*ROBW-1:0] rec_rob_id;
    logic [RHTW-1:0]   rec_rht_id;
    logic [IC-1:0]     wb_en = '0;
    logic [IC*ROBW-1:0] wb_rob_id = '0;
    logic              flush_en = 1'b0;
    logic [ROBW-1:0]   flush_rob_id = '0;
    logic              rec_en;
    logic              rec_busy;
    logic [IC-1:0]     valid_commit;
    logic [IC*ROBW-1:0] commit_rob_id;

    int tests = 0;
    int fails = 0;

    rr_rob_id_allocator #(.INSTR_COUNT(IC), .REC_CYCLES(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alloc_req     (alloc_req),
        .alloc_ready   (alloc_ready),
        .rec_rob_id    (rec_rob_id),
        .rec_rht_id    (rec_rht_id),
        .wb_en         (wb_en),
        .wb_rob_id     (wb_rob_id),
        .flush_en      (flush_en),
        .flush_rob_id  (flush_rob_id),
        .rec_en        (rec_en),
        .rec_busy      (rec_busy),
        .valid_commit  (valid_commit),
        .commit_rob_id (commit_rob_id)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sl(input logic [IC*ROBW-1:0] v,
                                       input int s);
        return 32'(v[s*ROBW +: ROBW]);
    endfunction

    task automatic set_wb(input logic [IC-1:0] en, input int id0,
                          input int id1);
        wb_en     = en;
        wb_rob_id = {ROBW'(id1), ROBW'(id0)};
    endtask

    task automatic do_reset();
        alloc_req = 1'b0;
        flush_en  = 1'b0;
        set_wb(2'b00, 0, 0);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        // reset values, visible without a clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rec_en", 32'(rec_en), 0);
        chk("rst_rec_busy", 32'(rec_busy), 0);
        chk("rst_valid_commit", 32'(valid_commit), 0);
        chk("rst_commit_id0", sl(commit_rob_id, 0), 0);
        chk("rst_rec_id0", sl(rec_rob_id, 0), 0);
        chk("rst_rec_id1", sl(rec_rob_id, 1), 1);
        chk("rst_rht", 32'(rec_rht_id), 0);
        chk("rst_ready", 32'(alloc_ready), 1);
        step();
        rst_n = 1'b1;

        // two packets
        alloc_req = 1'b1;
        chk("a0_id0", sl(rec_rob_id, 0), 0);
        chk("a0_id1", sl(rec_rob_id, 1), 1);
        chk("a0_rht", 32'(rec_rht_id), 0);
        step();
        chk("a1_id0", sl(rec_rob_id, 0), 2);
        chk("a1_id1", sl(rec_rob_id, 1), 3);
        chk("a1_rht", 32'(rec_rht_id), 1);
        step();
        alloc_req = 1'b0;
        chk("a_count", 32'(dut.rob_count_q), 4);

        // out-of-order writeback, in-order commit
        set_wb(2'b01, 1, 0);
        chk("wb1_vc", 32'(valid_commit), 0);
        step();
        set_wb(2'b01, 0, 0);
        chk("wb0_vc", 32'(valid_commit), 0);
        step();
        set_wb(2'b00, 0, 0);
        chk("cm_vc", 32'(valid_commit), 3);
        chk("cm_id0", sl(commit_rob_id, 0), 0);
        chk("cm_id1", sl(commit_rob_id, 1), 1);
        step();
        chk("cm_after_vc", 32'(valid_commit), 0);
        chk("cm_after_head", sl(commit_rob_id, 0), 2);
        chk("cm_after_count", 32'(dut.rob_count_q), 2);

        // fill to 96 and wrap
        do_reset();
        alloc_req = 1'b1;
        for (int k = 0; k < 48; k++) begin
            chk("fill_ready", 32'(alloc_ready), 1);
            if (k == 47) begin
                chk("fill_last_id0", sl(rec_rob_id, 0), 94);
                chk("fill_last_id1", sl(rec_rob_id, 1), 95);
                chk("fill_last_rht", 32'(rec_rht_id), 47);
            end
            step();
        end
        alloc_req = 1'b0;
        chk("full_ready", 32'(alloc_ready), 0);
        chk("full_count", 32'(dut.rob_count_q), 96);
        chk("full_id0", sl(rec_rob_id, 0), 0);
        set_wb(2'b11, 0, 1);
        step();
        set_wb(2'b00, 0, 0);
        chk("full_vc", 32'(valid_commit), 3);
        chk("full_cm_id1", sl(commit_rob_id, 1), 1);
        chk("full_ready_hold", 32'(alloc_ready), 0);
        step();
        chk("wrap_ready", 32'(alloc_ready), 1);
        chk("wrap_id0", sl(rec_rob_id, 0), 0);
        chk("wrap_id1", sl(rec_rob_id, 1), 1);
        chk("wrap_rht", 32'(rec_rht_id), 48);
        alloc_req = 1'b1;
        step();
        alloc_req = 1'b0;
        chk("wrap_full_ready", 32'(alloc_ready), 0);
        chk("wrap_next_id0", sl(rec_rob_id, 0), 2);
        chk("wrap_next_rht", 32'(rec_rht_id), 49);

        // flush at 5 with tail 10, commit and alloc in the same cycle
        do_reset();
        alloc_req = 1'b1;
        repeat (5) step();
        alloc_req = 1'b0;
        chk("fl_tail", sl(rec_rob_id, 0), 10);
        chk("fl_rht_tail", 32'(rec_rht_id), 5);
        set_wb(2'b11, 0, 1);
        step();
        set_wb(2'b00, 0, 0);
        flush_en     = 1'b1;
        flush_rob_id = ROBW'(5);
        alloc_req    = 1'b1;
        #1;
        chk("fl_ready_low", 32'(alloc_ready), 0);
        chk("fl_vc", 32'(valid_commit), 3);
        step();
        flush_en = 1'b0;
        chk("fl_rec_en", 32'(rec_en), 1);
        chk("fl_busy1", 32'(rec_busy), 1);
        chk("fl_id0", sl(rec_rob_id, 0), 6);
        chk("fl_id1", sl(rec_rob_id, 1), 7);
        chk("fl_rht", 32'(rec_rht_id), 3);
        chk("fl_ready_busy", 32'(alloc_ready), 0);
        chk("fl_head", sl(commit_rob_id, 0), 2);
        chk("fl_count", 32'(dut.rob_count_q), 4);
        chk("fl_rht_count", 32'(dut.rht_count_q), 2);
        step();
        chk("fl_rec_en_off", 32'(rec_en), 0);
        chk("fl_busy2", 32'(rec_busy), 1);
        step();
        step();
        chk("fl_busy4", 32'(rec_busy), 1);
        chk("fl_ready_busy4", 32'(alloc_ready), 0);
        step();
        chk("fl_busy_off", 32'(rec_busy), 0);
        chk("fl_ready_back", 32'(alloc_ready), 1);
        chk("fl_id0_held", sl(rec_rob_id, 0), 6);
        step();
        alloc_req = 1'b0;
        chk("fl_realloc_id0", sl(rec_rob_id, 0), 8);
        chk("fl_realloc_rht", 32'(rec_rht_id), 4);
        set_wb(2'b11, 2, 2);
        step();
        set_wb(2'b11, 3, 3);
        step();
        set_wb(2'b11, 4, 5);
        step();
        set_wb(2'b11, 6, 7);
        step();
        set_wb(2'b00, 0, 0);
        repeat (3) step();
        chk("fl_drain_vc", 32'(valid_commit), 0);
        chk("fl_drain_head", sl(commit_rob_id, 0), 8);
        chk("fl_drain_count", 32'(dut.rob_count_q), 0);
        chk("fl_drain_rht", 32'(dut.rht_count_q), 0);

        // asynchronous reset mid-stream during recovery
        alloc_req = 1'b1;
        repeat (10) step();
        alloc_req = 1'b0;
        chk("mr_count", 32'(dut.rob_count_q), 20);
        set_wb(2'b11, 8, 9);
        step();
        set_wb(2'b00, 0, 0);
        flush_en     = 1'b1;
        flush_rob_id = ROBW'(25);
        step();
        flush_en = 1'b0;
        chk("mr_rec_en", 32'(rec_en), 1);
        chk("mr_count_fl", 32'(dut.rob_count_q), 16);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_rec_en_rst", 32'(rec_en), 0);
        chk("mr_busy_rst", 32'(rec_busy), 0);
        chk("mr_vc_rst", 32'(valid_commit), 0);
        chk("mr_ready_rst", 32'(alloc_ready), 1);
        chk("mr_id0_rst", sl(rec_rob_id, 0), 0);
        chk("mr_id1_rst", sl(rec_rob_id, 1), 1);
        chk("mr_rht_rst", 32'(rec_rht_id), 0);
        chk("mr_head_rst", sl(commit_rob_id, 0), 0);
        step();
        rst_n = 1'b1;
        alloc_req = 1'b1;
        chk("mr_alloc_id0", sl(rec_rob_id, 0), 0);
        chk("mr_alloc_id1", sl(rec_rob_id, 1), 1);
        chk("mr_alloc_rht", 32'(rec_rht_id), 0);
        step();
        alloc_req = 1'b0;
        chk("mr_alloc_count", 32'(dut.rob_count_q), 2);
        chk("mr_alloc_next", sl(rec_rob_id, 0), 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
